// File: rtl/seg7_pkg.sv
// Shared types, glyph constants and the glyph-to-segment decode for the 7-segment scan driver.
package seg7_pkg;

    typedef logic [4:0] glyph_t;

    localparam glyph_t     GLYPH_DASH  = 5'd16;
    localparam glyph_t     GLYPH_DASH2 = 5'd17;
    localparam glyph_t     GLYPH_BLANK = 5'd31;
    localparam logic [7:0] SEG_OFF     = 8'hFF;

    // Active-low {g,f,e,d,c,b,a}; unknown codes go dark rather than all-on.
    function automatic logic [6:0] seg7_decode(input glyph_t g);
        logic [6:0] seg;
        case (g)
            5'd0:        seg = 7'b1000000;
            5'd1:        seg = 7'b1111001;
            5'd2:        seg = 7'b0100100;
            5'd3:        seg = 7'b0110000;
            5'd4:        seg = 7'b0011001;
            5'd5:        seg = 7'b0010010;
            5'd6:        seg = 7'b0000010;
            5'd7:        seg = 7'b1111000;
            5'd8:        seg = 7'b0000000;
            5'd9:        seg = 7'b0010000;
            5'd10:       seg = 7'b0001000;
            5'd11:       seg = 7'b0000011;
            5'd12:       seg = 7'b1000110;
            5'd13:       seg = 7'b0100001;
            5'd14:       seg = 7'b0000110;
            5'd15:       seg = 7'b0001110;
            GLYPH_DASH:  seg = 7'b0111111;
            GLYPH_DASH2: seg = 7'b0110111;
            GLYPH_BLANK: seg = 7'b1111111;
            default:     seg = 7'b1111111;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seg7_scan_driver_glyph_decode.sv
// Combinational glyph -> active-low segment decoder (dp excluded).
module seg7_glyph_decode
    import seg7_pkg::*;
(
    input  logic [4:0] i_glyph,
    output logic [6:0] o_seg_c
);

    assign o_seg_c = seg7_decode(glyph_t'(i_glyph));

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode 7-segment scan driver with frame-boundary double buffering.
// Optional per-digit blinking is enabled by defining SEG7_BLINK_EN.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int unsigned NUM_DIGITS  = 4,
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned GUARD_CYC   = 2
`ifdef SEG7_BLINK_EN
    ,
    parameter int unsigned BLINK_DIV   = 25
`endif
)(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [5*NUM_DIGITS-1:0]   digits_i,
    input  logic [NUM_DIGITS-1:0]     dp_i,
    input  logic [NUM_DIGITS-1:0]     blank_i,
`ifdef SEG7_BLINK_EN
    input  logic [NUM_DIGITS-1:0]     blink_i,
`endif
    input  logic                      load_i,
    output logic                      pending_o,
    output logic                      frame_o,
    output logic [NUM_DIGITS-1:0]     anode_o,
    output logic [7:0]                cathode_o
);

    localparam int unsigned CNT_W = $clog2(REFRESH_DIV);
    localparam int unsigned IDX_W = $clog2(NUM_DIGITS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LIT  = CNT_W'(GUARD_CYC);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0]               r_cnt;
    logic [IDX_W-1:0]               r_idx;
    logic                           r_frame;
    logic                           r_pending;
    logic [NUM_DIGITS-1:0]          r_anode;
    logic [7:0]                     r_cathode;
    glyph_t [NUM_DIGITS-1:0]        r_sh_dig,   r_act_dig;
    logic [NUM_DIGITS-1:0]          r_sh_dp,    r_act_dp;
    logic [NUM_DIGITS-1:0]          r_sh_blank, r_act_blank;

    glyph_t [NUM_DIGITS-1:0]        w_dig_in;
    logic                           w_slot_end;
    logic                           w_wrap;
    logic                           w_take_in;
    logic                           w_take_sh;
    logic                           w_dark;
    logic                           w_lit;
    logic [6:0]                     w_seg;
    logic [NUM_DIGITS-1:0]          w_anode;
    logic [7:0]                     w_cathode;

    assign w_dig_in   = digits_i;
    assign w_slot_end = (r_cnt == CNT_LAST);
    assign w_wrap     = w_slot_end && (r_idx == IDX_LAST);
    // A load on the wrap cycle goes straight to the active bank.
    assign w_take_in  = w_wrap && load_i;
    assign w_take_sh  = w_wrap && !load_i && r_pending;

`ifdef SEG7_BLINK_EN
    localparam int unsigned BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_DIV - 1);

    logic                  r_phase;
    logic [BLK_W-1:0]      r_blk_cnt;
    logic [NUM_DIGITS-1:0] r_sh_blink, r_act_blink;

    // Blink phase and blink-enable banks, buffered exactly like dp.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase     <= 1'b1;
            r_blk_cnt   <= '0;
            r_sh_blink  <= '0;
            r_act_blink <= '0;
        end else begin
            if (w_slot_end) begin
                if (r_blk_cnt == BLK_LAST) begin
                    r_blk_cnt <= '0;
                    r_phase   <= ~r_phase;
                end else begin
                    r_blk_cnt <= r_blk_cnt + BLK_W'(1);
                end
            end
            if (load_i)         r_sh_blink  <= blink_i;
            if (w_take_in)      r_act_blink <= blink_i;
            else if (w_take_sh) r_act_blink <= r_sh_blink;
        end
    end

    assign w_dark = r_act_blank[r_idx] | (r_act_blink[r_idx] & ~r_phase);
`else
    assign w_dark = r_act_blank[r_idx];
`endif

    assign w_lit = (r_cnt >= CNT_LIT) && !w_dark;

    seg7_glyph_decode u_decode (
        .i_glyph (r_act_dig[r_idx]),
        .o_seg_c (w_seg)
    );

    always_comb begin
        w_anode   = '1;
        w_cathode = SEG_OFF;
        if (w_lit) begin
            w_anode[r_idx] = 1'b0;
            w_cathode      = {~r_act_dp[r_idx], w_seg};
        end
    end

    // Prescaler, scan index, buffer banks and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_idx       <= '0;
            r_frame     <= 1'b0;
            r_pending   <= 1'b0;
            r_anode     <= '1;
            r_cathode   <= SEG_OFF;
            r_sh_dig    <= {NUM_DIGITS{GLYPH_BLANK}};
            r_act_dig   <= {NUM_DIGITS{GLYPH_BLANK}};
            r_sh_dp     <= '0;
            r_act_dp    <= '0;
            r_sh_blank  <= '1;
            r_act_blank <= '1;
        end else begin
            r_anode   <= w_anode;
            r_cathode <= w_cathode;
            r_frame   <= w_wrap;
            if (w_slot_end) begin
                r_cnt <= '0;
                r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + IDX_W'(1);
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (load_i) begin
                r_sh_dig   <= w_dig_in;
                r_sh_dp    <= dp_i;
                r_sh_blank <= blank_i;
            end
            if (w_take_in) begin
                r_act_dig   <= w_dig_in;
                r_act_dp    <= dp_i;
                r_act_blank <= blank_i;
                r_pending   <= 1'b0;
            end else if (w_take_sh) begin
                r_act_dig   <= r_sh_dig;
                r_act_dp    <= r_sh_dp;
                r_act_blank <= r_sh_blank;
                r_pending   <= 1'b0;
            end else if (load_i) begin
                r_pending   <= 1'b1;
            end
        end
    end

    assign pending_o = r_pending;
    assign frame_o   = r_frame;
    assign anode_o   = r_anode;
    assign cathode_o = r_cathode;

endmodule
